// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the generated-clock sequencer.
package clk_gen_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_RUN,
    ST_DRAIN,
    ST_LOAD,
    ST_SETTLE
  } state_t;

  localparam int DIV_MIN = 2;

  function automatic logic div_legal(input logic [31:0] div);
    return div >= 32'(DIV_MIN);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Integer divider: period counter, registered divided clock and end-of-period strobe.
module clk_div_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             clk_div_out,
  output logic             clk_en_pulse,
  output logic             period_end
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last_cnt;
  logic [DIV_W-1:0] half;

  assign last_cnt   = div - ONE;
  assign half       = div >> 1;
  assign period_end = en && (cnt >= last_cnt);

  // Outputs are registered from the current count, so the divided clock and
  // its strobe trail cnt by one clk_in cycle but stay aligned with each other.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      clk_div_out  <= 1'b0;
      clk_en_pulse <= 1'b0;
    end else if (clr) begin
      cnt          <= '0;
      clk_div_out  <= 1'b0;
      clk_en_pulse <= 1'b0;
    end else if (en) begin
      cnt          <= period_end ? '0 : cnt + ONE;
      clk_div_out  <= (cnt < half);
      clk_en_pulse <= period_end;
    end else begin
      clk_div_out  <= 1'b0;
      clk_en_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_gen_ctrl.sv
// Generated-clock sequencer: glitch-free ratio changes via drain, gate, load, settle.
module clk_gen_ctrl
  import clk_gen_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             clk_div_out,
  output logic             clk_en_pulse,
  output logic             gate_en,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYC - 1);

  state_t          state;
  logic            req_pend;
  logic [SC_W-1:0] settle_cnt;
  logic            req_new;
  logic            legal;
  logic            cnt_en;
  logic            period_end;

  // The requester still holds cfg_req in the ack cycle, so it is not a new request.
  assign req_new = cfg_req && !cfg_ack;
  assign legal   = div_legal(32'(cfg_div));
  assign cnt_en  = (state == ST_RUN) || (state == ST_DRAIN);
  assign gate_en = (state == ST_RUN);
  assign busy    = (state == ST_DRAIN) || (state == ST_LOAD) || (state == ST_SETTLE);

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (cnt_en),
    .clr         (!cnt_en),
    .div         (cur_div),
    .clk_div_out (clk_div_out),
    .clk_en_pulse(clk_en_pulse),
    .period_end  (period_end)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      req_pend   <= 1'b0;
      settle_cnt <= '0;
      cur_div    <= DIV_W'(DEFAULT_DIV);
      cfg_ack    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_OFF: begin
          if (req_new) begin
            if (legal) begin
              state <= ST_LOAD;
            end else begin
              cfg_ack <= 1'b1;
              cfg_err <= 1'b1;
            end
          end else if (run) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (req_new) begin
            state    <= ST_DRAIN;
            req_pend <= 1'b1;
          end else if (!run) begin
            state    <= ST_DRAIN;
            req_pend <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Only leave at a period boundary so the divided clock never emits a runt.
          if (period_end) begin
            req_pend <= 1'b0;
            if (req_pend && legal) begin
              state <= ST_LOAD;
            end else begin
              if (req_pend) begin
                cfg_ack <= 1'b1;
                cfg_err <= 1'b1;
              end
              state <= run ? ST_RUN : ST_OFF;
            end
          end
        end
        ST_LOAD: begin
          cur_div    <= cfg_div;
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SC_LAST) begin
            cfg_ack <= 1'b1;
            state   <= run ? ST_RUN : ST_OFF;
          end else begin
            settle_cnt <= settle_cnt + SC_W'(1);
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule
